// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester frame receive/transmit path.
// State encoding and default frame-format constants.
package manchester_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CRC
    } rx_state_e;

    localparam int          DEF_SYNC_W     = 16;
    localparam logic [15:0] DEF_SYNC_WORD  = 16'hD391;
    localparam int          DEF_MAX_LEN    = 32;
    localparam logic [7:0]  DEF_CRC_POLY   = 8'h07;
    localparam logic [7:0]  DEF_BCAST_ADDR = 8'hFF;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8, MSB first, init 0, no reflection, no final XOR.
// Shared by the frame receiver and the transmit framer.
module crc8_serial #(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic w_fb;

    assign w_fb = crc[7] ^ din;

    // clear wins over update; one bit folded in per enabled edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (w_fb ? POLY : 8'h00);
        end
    end

endmodule

// File: rtl/manchester_frame_rx.sv
// Sync hunter and LED command frame parser on the recovered bit clock.
// Level pulses are local; rx_tgl/frame_tgl are the cross-domain events.
module manchester_frame_rx
    import manchester_pkg::*;
#(
    parameter int                SYNC_W     = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_WORD  = DEF_SYNC_WORD,
    parameter int                MAX_LEN    = DEF_MAX_LEN,
    parameter logic [7:0]        CRC_POLY   = DEF_CRC_POLY,
    parameter logic [7:0]        BCAST_ADDR = DEF_BCAST_ADDR
) (
    input  logic       rst_n,
    input  logic       recovered_clk,
    input  logic       recovered_data,
    input  logic [7:0] my_addr,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_sof,
    output logic       rx_tgl,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       crc_err,
    output logic       len_err,
    output logic       frame_tgl,
    output logic [7:0] rx_addr,
    output logic [7:0] rx_len
);

    localparam logic [8:0] LMAX = 9'(MAX_LEN);

    rx_state_e         r_state;
    rx_state_e         w_next;
    logic [SYNC_W-2:0] r_sync;
    logic [6:0]        r_sh;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_bytecnt;
    logic              r_acc;
    logic              r_first;

    logic [SYNC_W-1:0] w_sync_nx;
    logic [7:0]        w_byte;
    logic              w_byte_done;
    logic [7:0]        w_crc;
    logic              w_crc_clr;
    logic              w_crc_en;
    logic              w_ld_addr;
    logic              w_ld_len;
    logic              w_len_bad;
    logic              w_pay;
    logic              w_fin;

    assign w_sync_nx   = {r_sync, recovered_data};
    assign w_byte      = {r_sh, recovered_data};
    assign w_byte_done = (r_bitcnt == 3'd7);
    assign w_crc_clr   = (r_state == S_HUNT);
    assign w_crc_en    = (r_state == S_ADDR) || (r_state == S_LEN) ||
                         (r_state == S_PAYLOAD);

    crc8_serial #(
        .POLY (CRC_POLY)
    ) u_crc (
        .clk   (recovered_clk),
        .rst_n (rst_n),
        .clr   (w_crc_clr),
        .en    (w_crc_en),
        .din   (recovered_data),
        .crc   (w_crc)
    );

    // state register
    always_ff @(posedge recovered_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    // next state and per-edge field strobes
    always_comb begin
        w_next    = r_state;
        w_ld_addr = 1'b0;
        w_ld_len  = 1'b0;
        w_len_bad = 1'b0;
        w_pay     = 1'b0;
        w_fin     = 1'b0;
        unique case (r_state)
            S_HUNT: begin
                if (w_sync_nx == SYNC_WORD) w_next = S_ADDR;
            end
            S_ADDR: begin
                if (w_byte_done) begin
                    w_ld_addr = 1'b1;
                    w_next    = S_LEN;
                end
            end
            S_LEN: begin
                if (w_byte_done) begin
                    w_ld_len = 1'b1;
                    if (w_byte == 8'd0 || {1'b0, w_byte} > LMAX) begin
                        w_len_bad = 1'b1;
                        w_next    = S_HUNT;
                    end else begin
                        w_next = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_byte_done) begin
                    w_pay = 1'b1;
                    if (r_bytecnt == 8'd1) w_next = S_CRC;
                end
            end
            S_CRC: begin
                if (w_byte_done) begin
                    w_fin  = 1'b1;
                    w_next = S_HUNT;
                end
            end
            default: w_next = S_HUNT;
        endcase
    end

    // datapath: shifters, counters, field latches and event outputs
    always_ff @(posedge recovered_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_sh       <= '0;
            r_bitcnt   <= '0;
            r_bytecnt  <= '0;
            r_acc      <= 1'b0;
            r_first    <= 1'b0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            rx_tgl     <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            frame_tgl  <= 1'b0;
            rx_addr    <= '0;
            rx_len     <= '0;
        end else begin
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            if (r_state == S_HUNT) begin
                r_sync   <= w_sync_nx[SYNC_W-2:0];
                r_bitcnt <= '0;
            end else begin
                r_sh     <= w_byte[6:0];
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_ld_addr) begin
                rx_addr <= w_byte;
                r_acc   <= (w_byte == my_addr) || (w_byte == BCAST_ADDR);
            end
            if (w_ld_len) begin
                rx_len    <= w_byte;
                r_bytecnt <= w_byte;
                r_first   <= 1'b1;
            end
            if (w_len_bad) begin
                len_err   <= 1'b1;
                frame_tgl <= ~frame_tgl;
                r_sync    <= '0;
            end
            if (w_pay) begin
                r_bytecnt <= r_bytecnt - 8'd1;
                r_first   <= 1'b0;
                if (r_acc) begin
                    rx_byte  <= w_byte;
                    rx_valid <= 1'b1;
                    rx_sof   <= r_first;
                    rx_tgl   <= ~rx_tgl;
                end
            end
            if (w_fin) begin
                frame_done <= 1'b1;
                frame_ok   <= (w_byte == w_crc) && r_acc;
                crc_err    <= (w_byte != w_crc);
                frame_tgl  <= ~frame_tgl;
                r_sync     <= '0;
            end
        end
    end

endmodule

// File: doc/manchester_frame_rx.md
Name: manchester_frame_rx

Overview:
Deframer directly downstream of the Manchester decoder. It is clocked by the decoder's recovered clock and samples its recovered data stream. It hunts for a sync word, then parses an LED command frame (ADDR, LEN, payload, CRC-8) and delivers payload bytes to the LED control core. Byte and frame events are also exported as toggle flags so the osc-domain consumer can synchronise them safely; recovered_clk stops when the line is idle.

Parameters:
SYNC_W, 16, sync word width in bits
SYNC_WORD, 16'hD391, sync pattern, MSB received first
MAX_LEN, 32, maximum payload length in bytes (legal LEN range 1..MAX_LEN)
CRC_POLY, 8'h07, CRC-8 polynomial (init 8'h00, no reflection, no final XOR)
BCAST_ADDR, 8'hFF, broadcast address accepted by every node

Ports:
rst_n  input  1  asynchronous, active-low reset
recovered_clk  input  1  bit clock from decoder; all logic on rising edge
recovered_data  input  1  serial data from decoder, MSB first
my_addr  input  8  node address, quasi-static
rx_byte  output  8  last payload byte
rx_valid  output  1  one-bit-time pulse: rx_byte new
rx_sof  output  1  qualifies rx_valid on the first payload byte
rx_tgl  output  1  toggles once per delivered payload byte (CDC)
frame_done  output  1  one-bit-time pulse at end of CRC field
frame_ok  output  1  with frame_done: CRC matched and address accepted
crc_err  output  1  with frame_done: CRC mismatch
len_err  output  1  one-bit-time pulse: LEN = 0 or LEN > MAX_LEN
frame_tgl  output  1  toggles on every frame_done or len_err
rx_addr  output  8  ADDR field of the current/last frame
rx_len  output  8  LEN field of the current/last frame

Behaviour:
- Reset (async, any state): state=HUNT; sync shift register, bit counter, byte counter and CRC cleared. All outputs are 0.
- Bit sample: recovered_data is captured on every rising recovered_clk edge.
- States: HUNT, ADDR, LEN, PAYLOAD, CRC.
- HUNT: shift each bit into a SYNC_W-bit register.
  - When {reg[SYNC_W-2:0], bit} == SYNC_WORD on an edge, enter ADDR at that edge. The bit counter and CRC are cleared.
  - Overlapping patterns are allowed; the register is not cleared on a miss.
- Byte assembly: an 8-bit shifter (MSB first) and a 3-bit counter. The edge that samples bit 7 completes the byte, which is visible after that edge.
- CRC: updated bitwise on every ADDR, LEN and PAYLOAD bit using CRC_POLY. The CRC field itself is not included.
- ADDR complete: latch rx_addr; accept if it equals my_addr or BCAST_ADDR; go to LEN.
- LEN complete: latch rx_len.
  - If 0 or > MAX_LEN: pulse len_err, toggle frame_tgl, return to HUNT with the sync register cleared.
  - Otherwise go to PAYLOAD with the byte counter = LEN.
- PAYLOAD, each complete byte:
  - If accepted: load rx_byte, pulse rx_valid, toggle rx_tgl. rx_sof is asserted on the first byte only.
  - Unaccepted frames are still parsed, but no byte outputs change.
  - Decrement the byte counter; after the last byte go to CRC.
- CRC complete:
  - Compare the received byte to the computed CRC.
  - Pulse frame_done; set frame_ok = match & accepted and crc_err = ~match.
  - Toggle frame_tgl, return to HUNT with the sync register cleared.
- Pulse width: pulses last exactly one recovered_clk period. If the clock stops, a pulse holds until the next edge. The osc domain must therefore use rx_tgl/frame_tgl with 2-flop sync plus edge detect, never the level pulses.
- Ordering guarantee: rx_byte is stable from its rx_tgl toggle until the next byte-completion edge (≥ 8 bit times).
- Reset mid-frame: the frame is discarded and no frame_done is issued.
- A new sync word inside a payload is not detected; resync only happens in HUNT.

Decomposition:
- Package manchester_pkg: state encoding enum, default SYNC_WORD, CRC_POLY, BCAST_ADDR, MAX_LEN.
- Sub-module crc8_serial (bit-serial CRC: clr, en, bit in, crc out) is natural and reusable by the TX framer.

Test Plan:
1. Basic frame. Stimulus: SYNC D391, ADDR 01, LEN 01, payload 55, CRC D2, my_addr=01. Response: one rx_valid with rx_sof, rx_byte=55, rx_tgl toggles once; frame_done with frame_ok=1, crc_err=0; rx_addr=01, rx_len=01.
2. Bad CRC. Stimulus: same frame with CRC D3. Response: rx_byte=55 delivered; frame_done with frame_ok=0, crc_err=1.
3. Address filtering.
   - my_addr=02, ADDR 01: no rx_valid, no rx_tgl toggle; frame_done with frame_ok=0, crc_err=0.
   - ADDR FF: bytes delivered and frame_ok=1.
4. Bad length. Stimulus: LEN=00 and LEN=MAX_LEN+1. Response: len_err pulse and frame_tgl toggle right after LEN, no payload output. A following valid frame is received correctly.
5. Sync hunting. Stimulus: random bits plus a partial sync (D3 90) before a full D391 frame, and a 32-byte max-length frame. Response: only the real frame is decoded, all 32 bytes arrive in order, rx_sof on byte 0 only.
6. Reset mid-payload. Stimulus: assert rst_n low after payload byte 2. Response: all outputs are 0 immediately, no frame_done; the next full frame decodes cleanly.
